// File: rtl/stage_sequencer.sv
// stage_sequencer: central controller for the multicycle CPU datapath.
// Boots from STALL (waits for the UART start byte) through LOAD (waits for the
// instruction loader), then steps each instruction through FETCH, DECODE,
// EXECUTE, MEMORY and WRITEREG, holding each stage for STAGE_LAT cycles.
// Ports:
//   clk, rstn              clock, synchronous active-low reset
//   rx_ready, rx_data      UART byte strobe and data
//   load_done              instruction loader finished
//   npc                    next PC, taken at the WRITEREG terminal edge
//   halt_req               decoded halt, sampled on the DECODE terminal cycle
//   stall_req              freezes the stage counter
//   mode, stage            current mode (STALL/LOAD/EXEC/HALT) and stage
//   pc, inst_count         current instruction address, retired count
//   lat_fd..lat_wd         one-cycle inter-stage latch enables (combinational)
//   busy                   mode is EXEC
module stage_sequencer #(
  parameter int unsigned STAGE_LAT  = 4,
  parameter int unsigned INST_SIZE  = 10,
  parameter logic [7:0]  START_BYTE = 8'hAA
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 rx_ready,
  input  logic [7:0]           rx_data,
  input  logic                 load_done,
  input  logic [INST_SIZE-1:0] npc,
  input  logic                 halt_req,
  input  logic                 stall_req,
  output logic [1:0]           mode,
  output logic [2:0]           stage,
  output logic [INST_SIZE-1:0] pc,
  output logic                 lat_fd,
  output logic                 lat_de,
  output logic                 lat_em,
  output logic                 lat_mw,
  output logic                 lat_wd,
  output logic                 busy,
  output logic [31:0]          inst_count
);

  localparam int unsigned CNT_W = (STAGE_LAT > 1) ? $clog2(STAGE_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STAGE_LAT - 1);

  typedef enum logic [1:0] {
    M_STALL = 2'd0,
    M_LOAD  = 2'd1,
    M_EXEC  = 2'd2,
    M_HALT  = 2'd3
  } mode_t;

  typedef enum logic [2:0] {
    S_FETCH    = 3'd0,
    S_DECODE   = 3'd1,
    S_EXECUTE  = 3'd2,
    S_MEMORY   = 3'd3,
    S_WRITEREG = 3'd4
  } stage_t;

  mode_t                mode_q;
  stage_t               stage_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 halt_q;
  logic [INST_SIZE-1:0] pc_q;
  logic [31:0]          count_q;
  logic                 term;

  // Last unstalled cycle of a stage; gated by rstn so no enable fires while resetting.
  assign term = rstn && (mode_q == M_EXEC) && (cnt_q == CNT_LAST) && !stall_req;

  // Enables are combinational so the datapath latches on the edge the stage advances.
  always_comb begin
    lat_fd = 1'b0;
    lat_de = 1'b0;
    lat_em = 1'b0;
    lat_mw = 1'b0;
    lat_wd = 1'b0;
    if (term) begin
      case (stage_q)
        S_FETCH:    lat_fd = 1'b1;
        S_DECODE:   lat_de = 1'b1;
        S_EXECUTE:  lat_em = 1'b1;
        S_MEMORY:   lat_mw = 1'b1;
        S_WRITEREG: lat_wd = 1'b1;
        default:    ;
      endcase
    end
  end

  // Mode/stage sequencing, PC and retired-instruction counter.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      mode_q  <= M_STALL;
      stage_q <= S_FETCH;
      cnt_q   <= '0;
      halt_q  <= 1'b0;
      pc_q    <= '0;
      count_q <= '0;
    end else begin
      case (mode_q)
        M_STALL: begin
          if (rx_ready && (rx_data == START_BYTE)) mode_q <= M_LOAD;
        end
        M_LOAD: begin
          if (load_done) begin
            mode_q  <= M_EXEC;
            stage_q <= S_FETCH;
            cnt_q   <= '0;
            pc_q    <= '0;
          end
        end
        M_EXEC: begin
          if (!stall_req) begin
            if (cnt_q != CNT_LAST) begin
              cnt_q <= cnt_q + CNT_W'(1);
            end else begin
              cnt_q <= '0;
              case (stage_q)
                S_FETCH:   stage_q <= S_DECODE;
                S_DECODE: begin
                  stage_q <= S_EXECUTE;
                  halt_q  <= halt_req;
                end
                S_EXECUTE: stage_q <= S_MEMORY;
                S_MEMORY:  stage_q <= S_WRITEREG;
                S_WRITEREG: begin
                  stage_q <= S_FETCH;
                  pc_q    <= npc;
                  count_q <= count_q + 32'd1;
                  if (halt_q) mode_q <= M_HALT;
                end
                default:   stage_q <= S_FETCH;
              endcase
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign mode       = mode_q;
  assign stage      = stage_q;
  assign pc         = pc_q;
  assign inst_count = count_q;
  assign busy       = (mode_q == M_EXEC);

endmodule

// File: doc/stage_sequencer.md
Name: stage_sequencer

Overview:
- Central controller for the multicycle CPU datapath.
- Handles boot: waits in idle for the UART start byte, then for instruction load to finish.
- Then steps each instruction through FETCH, DECODE, EXECUTE, MEMORY and WRITEREG, holding each stage for a fixed number of cycles.
- Issues one-cycle latch enables for the inter-stage registers, owns the PC and the retired-instruction counter, and supports stall and halt.

Parameters:
STAGE_LAT, 4, cycles spent in each stage (>=1)
INST_SIZE, 10, PC width in bits
START_BYTE, 8'hAA, UART byte that moves the core from STALL to LOAD

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
rx_ready  in  1  one-cycle strobe: rx_data valid
rx_data  in  8  received UART byte
load_done  in  1  instruction loader finished
npc  in  INST_SIZE  next PC from memory stage
halt_req  in  1  decoded instruction is a halt; valid in DECODE
stall_req  in  1  freeze the stage counter (e.g. memory busy)
mode  out  2  0=STALL 1=LOAD 2=EXEC 3=HALT
stage  out  3  0=FETCH 1=DECODE 2=EXECUTE 3=MEMORY 4=WRITEREG
pc  out  INST_SIZE  current instruction address
lat_fd  out  1  latch fetch->decode registers
lat_de  out  1  latch decode->execute registers
lat_em  out  1  latch execute->memory registers
lat_mw  out  1  latch memory->writeback registers
lat_wd  out  1  register-file write strobe (writeback->decode)
busy  out  1  mode==EXEC
inst_count  out  32  instructions retired

Behaviour:
- Reset is synchronous: rstn=0 sampled at a clk edge.
  - Reset values: mode=STALL, stage=FETCH, stage counter cnt=0, pc=0, inst_count=0, halt latch cleared.
  - Enables and busy are 0 from that edge.
  - Reset at any point, including mid-stage, aborts immediately. No enable fires in the reset cycle.
- STALL:
  - rx_ready=1 and rx_data==START_BYTE -> LOAD.
  - Any other byte is ignored.
  - load_done is ignored.
- LOAD:
  - load_done=1 -> EXEC, with stage=FETCH, cnt=0, pc=0.
  - rx traffic is ignored.
- EXEC:
  - cnt counts 0..STAGE_LAT-1. Its width is max(1, clog2(STAGE_LAT)).
  - Terminal cycle: cnt==STAGE_LAT-1 and stall_req=0.
  - stall_req=1 holds cnt and stage for that cycle, so no terminal occurs. A stall asserted on the terminal cycle delays the enable.
  - On terminal, the enable for the current stage is 1 for that cycle only. Enables are combinational from (mode, stage, cnt, stall_req), so the datapath latches on the same edge at which the stage advances. Mapping:
    - FETCH -> lat_fd
    - DECODE -> lat_de
    - EXECUTE -> lat_em
    - MEMORY -> lat_mw
    - WRITEREG -> lat_wd
  - At most one enable is high in any cycle.
  - Terminal edge: cnt<=0 and stage<=stage+1.
  - WRITEREG terminal edge: stage<=FETCH, pc<=npc, inst_count<=inst_count+1 (wraps at 2^32).
  - pc wraps naturally modulo 2^INST_SIZE.
- Halt:
  - halt_req is sampled only on the DECODE terminal cycle into a halt latch. Outside that cycle it is ignored.
  - The halted instruction still completes all stages, and its lat_wd fires.
  - At its WRITEREG terminal edge: mode<=HALT; pc and inst_count update as normal.
- HALT: all enables 0, all state frozen, busy=0. Exit only via reset.
- Timing: an unstalled instruction takes exactly 5*STAGE_LAT cycles. The first lat_fd occurs STAGE_LAT-1 cycles after the edge entering EXEC.
- Simultaneous events:
  - rx_ready together with load_done in STALL: only the STALL rule applies.
  - stall_req in STALL, LOAD or HALT has no effect.

Test Plan:
- Reset, then rx_ready with rx_data=8'h55 -> mode stays 0. Then rx_ready with 8'hAA -> mode=1 next cycle; pc=0 and all enables 0 throughout.
- In LOAD, pulse load_done -> mode=2, stage=0. lat_fd high exactly in cycle 3 after entry. lat_de/em/mw/wd follow in cycles 7, 11, 15, 19, each high for 1 cycle.
- npc=10'd5 held, no stalls -> after 20 cycles pc=5, inst_count=1, stage=0. After 40 cycles inst_count=2.
- stall_req high for 2 cycles during EXECUTE, at cnt=1 -> lat_em delayed by 2 cycles. Instruction takes 22 cycles; stall_req on the terminal cycle also defers that enable by 1.
- halt_req=1 only on the DECODE terminal cycle -> instruction completes, lat_wd fires, then mode=3 with no further enables for 100 cycles. halt_req asserted at DECODE cnt=0 only -> no halt.
- rstn low at MEMORY cnt=2 -> next edge mode=0, stage=0, pc=0, inst_count=0, no lat_mw pulse. A fresh 8'hAA restarts normally.
